// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   FWD_*        : EX ALU operand select encodings
//   hz_slot_t    : one scoreboard entry tracking an in-flight destination reg
//   REG_BITS_DEF : default register-number width
package pipe_hazard_ctl_pkg;

  localparam int unsigned REG_BITS_DEF = 5;
  // Slot register-number field is sized for the widest supported register file;
  // narrower register numbers are zero-extended into it.
  localparam int unsigned SLOT_WN_BITS = 8;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                    valid;
    logic                    wr_en;
    logic [SLOT_WN_BITS-1:0] wn;
    logic                    is_load;
  } hz_slot_t;

  localparam hz_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/pipe_hazard_ctl_hz_match.sv
// Compares one scoreboard slot against one ID source register.
//   i_valid/i_wr_en/i_wn : slot contents
//   i_src                : source register number (zero-extended)
//   i_use                : the ID instruction really reads this source
//   o_match_c            : combinational match; register 0 never matches
module hz_match
  import pipe_hazard_ctl_pkg::*;
(
  input  logic                    i_valid,
  input  logic                    i_wr_en,
  input  logic [SLOT_WN_BITS-1:0] i_wn,
  input  logic [SLOT_WN_BITS-1:0] i_src,
  input  logic                    i_use,
  output logic                    o_match_c
);

  assign o_match_c = i_use & i_valid & i_wr_en & (i_wn != '0) & (i_wn == i_src);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : decoded fields of the instruction in ID
//   ex_taken, int_req     : taken branch in EX, interrupt request
//   pc_en, ifid_en        : PC / IF-ID load enables (low while stalled)
//   ifid_flush, idex_flush: bubble insertion into IF/ID and ID/EX
//   fwd_a, fwd_b          : registered EX ALU operand selects
//   byp_a, byp_b          : ID register-file read takes the WB value
module pipe_hazard_ctl
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int unsigned REG_BITS = REG_BITS_DEF,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_wr_en,
  input  logic [REG_BITS-1:0] id_wn,
  input  logic                id_is_load,
  input  logic                id_jump,
  input  logic                ex_taken,
  input  logic                int_req,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                byp_a,
  output logic                byp_b
);

  hz_slot_t r_ex, r_mem, r_wb;
  logic [1:0] r_fwd_a, r_fwd_b;

  logic [SLOT_WN_BITS-1:0] w_rs_x, w_rt_x, w_wn_x;
  logic       w_use_a, w_use_b;
  hz_slot_t   w_slot [3];
  hz_slot_t   w_id_slot;
  logic [2:0] w_hit_a, w_hit_b;
  logic       w_ld_use, w_raw_near, w_stall_req, w_stall;
  logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;
  logic       w_unused;

  assign w_rs_x  = SLOT_WN_BITS'(id_rs);
  assign w_rt_x  = SLOT_WN_BITS'(id_rt);
  assign w_wn_x  = SLOT_WN_BITS'(id_wn);
  assign w_use_a = id_valid & id_uses_rs;
  assign w_use_b = id_valid & id_uses_rt;

  assign w_slot[0] = r_ex;
  assign w_slot[1] = r_mem;
  assign w_slot[2] = r_wb;

  // A load that has reached WB has no further hazard role.
  assign w_unused = r_wb.is_load;

  // Slot-vs-source comparators: index 0 = EX, 1 = MEM, 2 = WB.
  for (genvar g = 0; g < 3; g++) begin : g_match
    hz_match u_match_a (
      .i_valid  (w_slot[g].valid),
      .i_wr_en  (w_slot[g].wr_en),
      .i_wn     (w_slot[g].wn),
      .i_src    (w_rs_x),
      .i_use    (w_use_a),
      .o_match_c(w_hit_a[g])
    );
    hz_match u_match_b (
      .i_valid  (w_slot[g].valid),
      .i_wr_en  (w_slot[g].wr_en),
      .i_wn     (w_slot[g].wn),
      .i_src    (w_rt_x),
      .i_use    (w_use_b),
      .o_match_c(w_hit_b[g])
    );
  end

  // Without forwarding, any producer still in EX or MEM blocks the consumer.
  assign w_ld_use    = r_ex.is_load & (w_hit_a[0] | w_hit_b[0]);
  assign w_raw_near  = |{w_hit_a[1:0], w_hit_b[1:0]};
  assign w_stall_req = FWD_EN ? w_ld_use : w_raw_near;
  assign w_stall     = w_stall_req & ~int_req & ~ex_taken & ~reset;

  // Pipeline control, priority reset > int_req > ex_taken > stall > jump.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset) begin
      if (int_req || ex_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_stall_req) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_valid && id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign byp_a = ~reset & ~w_stall & w_hit_a[2];
  assign byp_b = ~reset & ~w_stall & w_hit_b[2];

  // Operand select for the instruction about to enter EX; nearer producer wins.
  always_comb begin
    w_fwd_a_nxt = FWD_REG;
    w_fwd_b_nxt = FWD_REG;
    if (FWD_EN) begin
      if (w_hit_a[0])      w_fwd_a_nxt = FWD_EXMEM;
      else if (w_hit_a[1]) w_fwd_a_nxt = FWD_MEMWB;
      if (w_hit_b[0])      w_fwd_b_nxt = FWD_EXMEM;
      else if (w_hit_b[1]) w_fwd_b_nxt = FWD_MEMWB;
    end
  end

  always_comb begin
    w_id_slot         = SLOT_EMPTY;
    w_id_slot.valid   = id_valid;
    w_id_slot.wr_en   = id_wr_en;
    w_id_slot.wn      = w_wn_x;
    w_id_slot.is_load = id_is_load;
  end

  // Scoreboard shift and forward-select capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex    <= SLOT_EMPTY;
      r_mem   <= SLOT_EMPTY;
      r_wb    <= SLOT_EMPTY;
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (idex_flush) begin
        r_ex    <= SLOT_EMPTY;
        r_fwd_a <= FWD_REG;
        r_fwd_b <= FWD_REG;
      end else begin
        r_ex    <= w_id_slot;
        r_fwd_a <= w_fwd_a_nxt;
        r_fwd_b <= w_fwd_b_nxt;
      end
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: u0 with forwarding, u1 stall-only.
module tb_pipe_hazard_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_jump;
  logic [4:0] id_rs, id_rt, id_wn;
  logic       ex_taken, int_req;

  logic       pc_en0, ifid_en0, ifid_flush0, idex_flush0, byp_a0, byp_b0;
  logic [1:0] fwd_a0, fwd_b0;
  logic       pc_en1, ifid_en1, ifid_flush1, idex_flush1, byp_a1, byp_b1;
  logic [1:0] fwd_a1, fwd_b1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctl #(.REG_BITS(5), .FWD_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_wn(id_wn), .id_is_load(id_is_load), .id_jump(id_jump),
    .ex_taken(ex_taken), .int_req(int_req),
    .pc_en(pc_en0), .ifid_en(ifid_en0), .ifid_flush(ifid_flush0),
    .idex_flush(idex_flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
    .byp_a(byp_a0), .byp_b(byp_b0)
  );

  pipe_hazard_ctl #(.REG_BITS(5), .FWD_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_wn(id_wn), .id_is_load(id_is_load), .id_jump(id_jump),
    .ex_taken(ex_taken), .int_req(int_req),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
    .idex_flush(idex_flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .byp_a(byp_a1), .byp_b(byp_b1)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // ctl = {pc_en, ifid_en, ifid_flush, idex_flush}; fwd = {fwd_a, fwd_b}; byp = {00, byp_a, byp_b}
  task automatic chk_ctl0(input string tag, input logic [3:0] exp);
    chk(tag, {pc_en0, ifid_en0, ifid_flush0, idex_flush0}, exp);
  endtask
  task automatic chk_ctl1(input string tag, input logic [3:0] exp);
    chk(tag, {pc_en1, ifid_en1, ifid_flush1, idex_flush1}, exp);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_wr_en = 1'b0; id_wn = '0; id_is_load = 1'b0; id_jump = 1'b0;
    ex_taken = 1'b0; int_req = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic wr, input logic [4:0] wn,
                        input logic ld, input logic jmp);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_wr_en = wr; id_wn = wn; id_is_load = ld; id_jump = jmp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk_ctl0("rst_ctl", 4'b1100);
    chk("rst_fwd", {fwd_a0, fwd_b0}, 4'b0000);
    chk("rst_byp", {2'b00, byp_a0, byp_b0}, 4'b0000);
    chk_ctl1("rst_ctl_nofwd", 4'b1100);

    // add $3,$1,$2 ; sub $4,$3,$5 -> fwd_a=01
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); #1;
    chk_ctl0("addsub_add_ctl", 4'b1100);
    tick();
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0); #1;
    chk_ctl0("addsub_sub_ctl", 4'b1100);
    tick(); idle();
    chk("addsub_fwd", {fwd_a0, fwd_b0}, 4'b0100);

    // lw $3,0($1) ; add $4,$3,$3 -> one stall, then fwd 10/10
    repeat (2) tick();
    set_id(5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    chk_ctl0("lu_lw_ctl", 4'b1100);
    tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0); #1;
    chk_ctl0("lu_stall", 4'b0001);
    tick(); #1;
    chk_ctl0("lu_release", 4'b1100);
    tick(); idle();
    chk("lu_fwd", {fwd_a0, fwd_b0}, 4'b1010);

    // add $3 ; two unrelated ; or $6,$3,$0 -> byp_a
    repeat (3) tick();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); tick();
    set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0); tick();
    set_id(5'd11, 5'd12, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0); tick();
    set_id(5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0); #1;
    chk("byp_or", {2'b00, byp_a0, byp_b0}, 4'b0010);
    chk_ctl0("byp_or_ctl", 4'b1100);
    tick(); idle();
    chk("byp_or_fwd", {fwd_a0, fwd_b0}, 4'b0000);

    // writes to $0 never create hazards
    repeat (3) tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0); #1;
    chk_ctl0("r0_ctl", 4'b1100);
    chk("r0_byp", {2'b00, byp_a0, byp_b0}, 4'b0000);
    tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0); #1;
    chk("r0_fwd", {fwd_a0, fwd_b0}, 4'b0000);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0); #1;
    chk_ctl0("r0_load_ctl", 4'b1100);

    // taken branch overrides load-use stall
    tick(); idle(); repeat (3) tick();
    set_id(5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    ex_taken = 1'b1; #1;
    chk_ctl0("br_ctl", 4'b1111);
    chk("br_byp", {2'b00, byp_a0, byp_b0}, 4'b0000);
    tick(); idle();
    chk("br_fwd", {fwd_a0, fwd_b0}, 4'b0000);

    // jump alone, then jump behind a load-use stall
    repeat (3) tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
    chk_ctl0("j_ctl", 4'b1110);
    tick(); idle(); repeat (3) tick();
    set_id(5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
    chk_ctl0("jst_stall", 4'b0001);
    tick(); #1;
    chk_ctl0("jst_flush", 4'b1110);

    // interrupt with j in ID, then interrupt over a load-use stall
    tick(); idle(); repeat (3) tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    int_req = 1'b1; #1;
    chk_ctl0("int_j_ctl", 4'b1111);
    tick(); idle(); repeat (3) tick();
    set_id(5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    int_req = 1'b1; #1;
    chk_ctl0("int_lu_ctl", 4'b1111);
    int_req = 1'b0; #1;
    chk_ctl0("int_lu_back", 4'b0001);

    // reset during the stall clears the scoreboard
    reset = 1'b1; #1;
    chk_ctl0("rst_mid_ctl", 4'b1100);
    tick();
    reset = 1'b0; #1;
    chk_ctl0("rst_after_ctl", 4'b1100);
    chk("rst_after_fwd", {fwd_a0, fwd_b0}, 4'b0000);

    // FWD_EN=0: add/sub pair stalls two cycles, then reads via WB bypass
    idle(); repeat (3) tick();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); tick();
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0); #1;
    chk_ctl1("nf_stall1", 4'b0001);
    chk_ctl0("nf_fwd_dut_ctl", 4'b1100);
    tick(); #1;
    chk_ctl1("nf_stall2", 4'b0001);
    tick(); #1;
    chk_ctl1("nf_release", 4'b1100);
    chk("nf_byp", {2'b00, byp_a1, byp_b1}, 4'b0010);
    tick(); idle();
    chk("nf_fwd", {fwd_a1, fwd_b1}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
